// File: rtl/ksched_pkg.sv
// Shared definitions for key_space_scheduler: FSM state encoding, default key-space
// constants and a pointer-width helper used by the scheduler and its arbiter.
package ksched_pkg;

  typedef enum logic [1:0] {
    KS_IDLE      = 2'd0,
    KS_RUN       = 2'd1,
    KS_FOUND     = 2'd2,
    KS_EXHAUSTED = 2'd3
  } ksched_state_t;

  localparam int KSCHED_KEY_WIDTH = 22;
  localparam logic [KSCHED_KEY_WIDTH-1:0] KSCHED_KEY_MAX = 22'h3FFFFF;

  // A single core still needs a one-bit pointer so port widths never collapse to zero.
  function automatic int ksched_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first requester
// found when scanning upward from 'pointer' and wrapping around.
module rr_arbiter
  import ksched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ksched_ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  gnt
);

  localparam logic [N-1:0] L_ONE = N'(1);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_pick;

  // Rotate so the pointer lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_rot  = (req >> pointer) | (req << (N - int'(pointer)));
    w_pick = w_rot & (~w_rot + L_ONE);
    gnt    = (w_pick << pointer) | (w_pick >> (N - int'(pointer)));
  end

endmodule

// File: rtl/key_space_scheduler.sv
// Hands out consecutive secret keys to a pool of decryptor cores and stops them all on
// the first hit or once the key space is used up. Optional RUN-cycle counter: KSCHED_CYCLE_COUNT_EN.
module key_space_scheduler
  import ksched_pkg::*;
#(
  parameter int                    CORE_COUNT = 4,
  parameter int                    KEY_WIDTH  = KSCHED_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0]  KEY_MAX    = KEY_WIDTH'(KSCHED_KEY_MAX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CORE_COUNT-1:0] req,
  output logic [CORE_COUNT-1:0] gnt,
  output logic [KEY_WIDTH-1:0]  key_out,
  input  logic [CORE_COUNT-1:0] done,
  input  logic [CORE_COUNT-1:0] hit,
  output logic                  stop_all,
  output logic [KEY_WIDTH-1:0]  found_key,
  output logic                  solved,
  output logic                  exhausted,
  output logic                  busy,
  output logic [31:0]           cycle_count
);

  localparam int PW = ksched_ptr_width(CORE_COUNT);

  ksched_state_t r_state;
  ksched_state_t w_state_next;

  logic [CORE_COUNT-1:0] r_gnt;
  logic [KEY_WIDTH-1:0]  r_key_out;
  logic [KEY_WIDTH-1:0]  r_found_key;
  logic [KEY_WIDTH-1:0]  r_next_key;
  logic                  r_keys_done;
  logic [CORE_COUNT-1:0] r_outstanding;
  logic [PW-1:0]         r_ptr;
  logic [KEY_WIDTH-1:0]  r_core_key [CORE_COUNT];

  logic [CORE_COUNT-1:0] w_done_vld;
  logic [CORE_COUNT-1:0] w_hit_vec;
  logic                  w_any_hit;
  logic [KEY_WIDTH-1:0]  w_hit_key;
  logic [CORE_COUNT-1:0] w_elig;
  logic [CORE_COUNT-1:0] w_arb_gnt;
  logic                  w_grant_en;
  logic [CORE_COUNT-1:0] w_grant_vec;
  logic [CORE_COUNT-1:0] w_out_next;
  logic [PW-1:0]         w_ptr_next;
  logic                  w_enter_run;

  // Results only count for cores that actually hold a key; requests from key holders
  // and all requests after the last key are masked before arbitration.
  assign w_done_vld  = done & r_outstanding;
  assign w_hit_vec   = w_done_vld & hit;
  assign w_any_hit   = |w_hit_vec;
  assign w_elig      = req & ~r_outstanding & {CORE_COUNT{~r_keys_done}};
  assign w_grant_en  = (r_state == KS_RUN) && !w_any_hit && (|w_arb_gnt);
  assign w_grant_vec = w_grant_en ? w_arb_gnt : '0;
  assign w_out_next  = (r_outstanding & ~w_done_vld) | w_grant_vec;
  assign w_enter_run = start && (r_state != KS_RUN);

  rr_arbiter #(
    .N  (CORE_COUNT),
    .PW (PW)
  ) u_rr_arbiter (
    .req     (w_elig),
    .pointer (r_ptr),
    .gnt     (w_arb_gnt)
  );

  // Downward scan so the lowest-indexed hitting core wins; the same loop derives
  // the pointer value one past the granted core.
  always_comb begin
    w_hit_key  = '0;
    w_ptr_next = r_ptr;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_key = r_core_key[i];
      end
      if (w_arb_gnt[i]) begin
        w_ptr_next = (i == CORE_COUNT - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= KS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      KS_IDLE, KS_FOUND, KS_EXHAUSTED: begin
        if (start) begin
          w_state_next = KS_RUN;
        end
      end
      KS_RUN: begin
        if (w_any_hit) begin
          w_state_next = KS_FOUND;
        end else if (r_keys_done && (w_out_next == '0)) begin
          w_state_next = KS_EXHAUSTED;
        end
      end
      default: w_state_next = KS_IDLE;
    endcase
  end

  // Key issue datapath; r_keys_done pins next_key at KEY_MAX instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt         <= '0;
      r_key_out     <= '0;
      r_found_key   <= '0;
      r_next_key    <= '0;
      r_keys_done   <= 1'b0;
      r_outstanding <= '0;
      r_ptr         <= '0;
      for (int i = 0; i < CORE_COUNT; i++) begin
        r_core_key[i] <= '0;
      end
    end else if (w_enter_run) begin
      r_gnt         <= '0;
      r_found_key   <= '0;
      r_next_key    <= '0;
      r_keys_done   <= 1'b0;
      r_outstanding <= '0;
      r_ptr         <= '0;
    end else if (r_state == KS_RUN) begin
      r_gnt         <= w_grant_vec;
      r_outstanding <= w_out_next;
      if (w_any_hit) begin
        r_found_key <= w_hit_key;
      end
      if (w_grant_en) begin
        r_key_out <= r_next_key;
        r_ptr     <= w_ptr_next;
        for (int i = 0; i < CORE_COUNT; i++) begin
          if (w_arb_gnt[i]) begin
            r_core_key[i] <= r_next_key;
          end
        end
        if (r_next_key == KEY_MAX) begin
          r_keys_done <= 1'b1;
        end else begin
          r_next_key <= r_next_key + KEY_WIDTH'(1);
        end
      end
    end else begin
      r_gnt <= '0;
    end
  end

  assign gnt       = r_gnt;
  assign key_out   = r_key_out;
  assign found_key = r_found_key;
  assign solved    = (r_state == KS_FOUND);
  assign exhausted = (r_state == KS_EXHAUSTED);
  assign busy      = (r_state == KS_RUN);
  assign stop_all  = solved || exhausted;

`ifdef KSCHED_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  // Counts cycles spent in RUN, saturating rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
    end else if (w_enter_run) begin
      r_cycle_count <= '0;
    end else if ((r_state == KS_RUN) && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_key_space_scheduler.sv
// Directed bench for key_space_scheduler: a default-size instance for grant, hit and reset
// behaviour plus a KEY_MAX=5 instance for key-space exhaustion.
module tb_key_space_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [3:0]  req, done, hit;
  logic [3:0]  gnt;
  logic [21:0] keyOut, foundKey;
  logic        stopAll, solved, exhausted, busy;
  logic [31:0] cycleCount;

  logic        sStart;
  logic [3:0]  sReq, sDone, sHit;
  logic [3:0]  sGnt;
  logic [21:0] sKeyOut, sFoundKey;
  logic        sStopAll, sSolved, sExhausted, sBusy;
  logic [31:0] sCycleCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_space_scheduler dut (
    .clk(clk), .reset_n(resetN), .start(start), .req(req), .gnt(gnt),
    .key_out(keyOut), .done(done), .hit(hit), .stop_all(stopAll),
    .found_key(foundKey), .solved(solved), .exhausted(exhausted),
    .busy(busy), .cycle_count(cycleCount)
  );

  key_space_scheduler #(.CORE_COUNT(4), .KEY_WIDTH(22), .KEY_MAX(22'd5)) dutSmall (
    .clk(clk), .reset_n(resetN), .start(sStart), .req(sReq), .gnt(sGnt),
    .key_out(sKeyOut), .done(sDone), .hit(sHit), .stop_all(sStopAll),
    .found_key(sFoundKey), .solved(sSolved), .exhausted(sExhausted),
    .busy(sBusy), .cycle_count(sCycleCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] r, input logic [3:0] d, input logic [3:0] h);
    start = s;
    req   = r;
    done  = d;
    hit   = h;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
    sStart = 1'b0; sReq = '0; sDone = '0; sHit = '0;
    #1;
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstKeyOut", 32'(keyOut), 32'd0);
    checkOutput("rstFoundKey", 32'(foundKey), 32'd0);
    checkOutput("rstStopAll", 32'(stopAll), 32'd0);
    checkOutput("rstSolved", 32'(solved), 32'd0);
    checkOutput("rstExhausted", 32'(exhausted), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCycleCount", cycleCount, 32'd0);
    stepCycle();
    stepCycle();
    resetN = 1'b1;

    // Round-robin over four requesting cores, then silence while all hold keys
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("runBusy", 32'(busy), 32'd1);
    checkOutput("runStopAll", 32'(stopAll), 32'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("rrGnt", 32'(gnt), 32'(1 << i));
      checkOutput("rrKey", 32'(keyOut), 32'(i));
    end
    stepCycle();
    checkOutput("heldNoGnt", 32'(gnt), 32'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b1111);
    stepCycle();
    checkOutput("hitWithoutDone", 32'(solved), 32'd0);
    checkOutput("hitWithoutDoneGnt", 32'(gnt), 32'd0);

    // Free core 2, then core 0, then core 2 again so core 2 ends up holding key 6
    applyStimulus(1'b0, 4'b1111, 4'b0100, 4'b0000);
    stepCycle();
    checkOutput("doneCycleGnt", 32'(gnt), 32'd0);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("regrantGnt2", 32'(gnt), 32'b0100);
    checkOutput("regrantKey4", 32'(keyOut), 32'd4);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("regrantGnt0", 32'(gnt), 32'b0001);
    checkOutput("regrantKey5", 32'(keyOut), 32'd5);
    applyStimulus(1'b0, 4'b1111, 4'b0100, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("regrantGnt2b", 32'(gnt), 32'b0100);
    checkOutput("regrantKey6", 32'(keyOut), 32'd6);

    // Core 1 becomes eligible; core 2 then hits in the same cycle as core 1 requests
    applyStimulus(1'b0, 4'b1111, 4'b0010, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b1111, 4'b0100, 4'b0100);
    stepCycle();
    checkOutput("foundGnt", 32'(gnt), 32'd0);
    checkOutput("foundSolved", 32'(solved), 32'd1);
    checkOutput("foundStopAll", 32'(stopAll), 32'd1);
    checkOutput("foundBusy", 32'(busy), 32'd0);
    checkOutput("foundKey6", 32'(foundKey), 32'd6);
    applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("foundHoldGnt", 32'(gnt), 32'd0);
    checkOutput("foundHoldKey", 32'(foundKey), 32'd6);

    // Restart from FOUND; a result from a core holding no key must be ignored
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("restartBusy", 32'(busy), 32'd1);
    checkOutput("restartFoundKey", 32'(foundKey), 32'd0);
    checkOutput("restartStopAll", 32'(stopAll), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0001);
    stepCycle();
    checkOutput("staleHitSolved", 32'(solved), 32'd0);
    checkOutput("staleHitBusy", 32'(busy), 32'd1);

    // Three full rounds: cores 1 and 2 end up with keys 9 and 10 and hit together
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, 4'b0000);
      for (int i = 0; i < 4; i++) begin
        stepCycle();
        checkOutput("roundGnt", 32'(gnt), 32'(1 << i));
        checkOutput("roundKey", 32'(keyOut), 32'(r * 4 + i));
      end
      if (r < 2) begin
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'b0000);
        stepCycle();
        checkOutput("roundDoneGnt", 32'(gnt), 32'd0);
      end
    end
    applyStimulus(1'b0, 4'b1111, 4'b0110, 4'b0110);
    stepCycle();
    checkOutput("dualHitSolved", 32'(solved), 32'd1);
    checkOutput("dualHitKey9", 32'(foundKey), 32'd9);

    // Hit sampled on the 20th RUN cycle
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("cntGnt", 32'(gnt), 32'b0001);
    checkOutput("cntKey", 32'(keyOut), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
    repeat (18) stepCycle();
    checkOutput("cntStillBusy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0001);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("cntSolved", 32'(solved), 32'd1);
`ifdef KSCHED_CYCLE_COUNT_EN
    checkOutput("cycleCount", cycleCount, 32'd20);
    stepCycle();
    checkOutput("cycleCountHold", cycleCount, 32'd20);
`else
    checkOutput("cycleCount", cycleCount, 32'd0);
    stepCycle();
    checkOutput("cycleCountHold", cycleCount, 32'd0);
`endif

    // Reset while three cores hold keys
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b0111, 4'b0000, 4'b0000);
    repeat (3) stepCycle();
    checkOutput("preRstGnt", 32'(gnt), 32'b0100);
    checkOutput("preRstKey", 32'(keyOut), 32'd2);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midRstGnt", 32'(gnt), 32'd0);
    checkOutput("midRstKeyOut", 32'(keyOut), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstCycleCount", cycleCount, 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0111, 4'b0111);
    stepCycle();
    resetN = 1'b1;
    stepCycle();
    checkOutput("postRstSolved", 32'(solved), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    applyStimulus(1'b0, 4'b0000, 4'b0111, 4'b0111);
    stepCycle();
    checkOutput("postRstStaleHit", 32'(solved), 32'd0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("postRstGnt", 32'(gnt), 32'b0001);
    checkOutput("postRstKey0", 32'(keyOut), 32'd0);

    // Exhaustion with KEY_MAX=5
    sStart = 1'b1;
    stepCycle();
    sStart = 1'b0;
    checkOutput("exBusy", 32'(sBusy), 32'd1);
    sReq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("exGnt", 32'(sGnt), 32'(1 << i));
      checkOutput("exKey", 32'(sKeyOut), 32'(i));
    end
    sDone = 4'b1111;
    stepCycle();
    checkOutput("exDoneGnt", 32'(sGnt), 32'd0);
    sDone = 4'b0000;
    stepCycle();
    checkOutput("exGnt4", 32'(sGnt), 32'b0001);
    checkOutput("exKey4", 32'(sKeyOut), 32'd4);
    stepCycle();
    checkOutput("exGnt5", 32'(sGnt), 32'b0010);
    checkOutput("exKey5", 32'(sKeyOut), 32'd5);
    stepCycle();
    checkOutput("exNoWrapGnt", 32'(sGnt), 32'd0);
    checkOutput("exNoWrapBusy", 32'(sBusy), 32'd1);
    sDone = 4'b0001;
    stepCycle();
    checkOutput("exPartialExh", 32'(sExhausted), 32'd0);
    checkOutput("exPartialGnt", 32'(sGnt), 32'd0);
    sDone = 4'b0010;
    stepCycle();
    sDone = 4'b0000;
    checkOutput("exExhausted", 32'(sExhausted), 32'd1);
    checkOutput("exStopAll", 32'(sStopAll), 32'd1);
    checkOutput("exBusyLow", 32'(sBusy), 32'd0);
    checkOutput("exSolved", 32'(sSolved), 32'd0);
    checkOutput("exFinalGnt", 32'(sGnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
